// File: rtl/overcurrent_guard_nch.sv
// overcurrent_guard_nch
//   N-channel latched overcurrent supervisor. Each channel has its own
//   debounced threshold trip, relay latch-open and level clear. All
//   channels share one startup blanking timer and one active-low buzzer.
//   Compile-time option: define AUTORECLOSE_EN to add a timed auto-reclose.
//   The reclose count is limited. The trip after the last allowed reclose
//   latches the channel in lockout.
module overcurrent_guard_nch #(
  parameter int N_CH        = 3,
  parameter int DW          = 16,
  parameter int TRIP_THR    = 500,
  parameter int NEG_LIMIT   = 32000,
  parameter int DEBOUNCE    = 1000,
  parameter int STARTUP_CYC = 150000000,
  parameter int RECLOSE_CYC = 50000000,
  parameter int MAX_RECLOSE = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH*DW-1:0] sample_i,
  input  logic [N_CH-1:0]    clr_i,
  output logic [N_CH-1:0]    relay_o,
  output logic               buzzer_o,
  output logic [N_CH-1:0]    trip_o,
  output logic [N_CH-1:0]    pend_o,
  output logic               armed_o
);

  // Counter widths follow $clog2(terminal+1). Each width is floored at one bit.
  localparam int SW = (STARTUP_CYC < 2) ? 1 : $clog2(STARTUP_CYC + 1);
  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
`ifdef AUTORECLOSE_EN
  localparam int RW = (RECLOSE_CYC < 2) ? 1 : $clog2(RECLOSE_CYC + 1);
  localparam int AW = (MAX_RECLOSE < 1) ? 1 : $clog2(MAX_RECLOSE + 1);
`endif

  // Comparisons are DW bits wide and unsigned. A negative reading from the
  // INA219 appears as a large value, and NEG_LIMIT excludes it.
  localparam logic [DW-1:0] THR = DW'(TRIP_THR);
  localparam logic [DW-1:0] NEG = DW'(NEG_LIMIT);

  // Reject impossible configurations at elaboration time.
  if (N_CH < 1 || N_CH > 16 || DW < 2 || DEBOUNCE < 1 || STARTUP_CYC < 1 ||
      RECLOSE_CYC < 1 || MAX_RECLOSE < 1 || NEG_LIMIT <= TRIP_THR) begin : g_bad_params
    $error("overcurrent_guard_nch: parameter out of range");
  end

`ifdef AUTORECLOSE_EN
  typedef enum logic [2:0] {
    ST_NORMAL = 3'd0,
    ST_PEND   = 3'd1,
    ST_TRIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCK   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_PEND   = 2'd1,
    ST_TRIP   = 2'd2
  } state_t;
`endif

  logic [SW-1:0]   start_cnt;
  logic            armed;
  logic [N_CH-1:0] active;

  // Startup blanking: count 0..STARTUP_CYC-1, then arm on the following edge and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
      armed     <= 1'b0;
    end else if (!armed) begin
      if (start_cnt == SW'(STARTUP_CYC - 1)) begin
        armed <= 1'b1;
      end else begin
        start_cnt <= start_cnt + SW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [DW-1:0] sample;
    logic          over;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
`ifdef AUTORECLOSE_EN
    logic [RW-1:0] timer;
    logic [RW-1:0] timer_next;
    logic [AW-1:0] attempts;
    logic [AW-1:0] attempts_next;
`endif

    assign sample = sample_i[gi*DW +: DW];
    assign over   = (sample > THR) && (sample < NEG);

    // Per-channel state register. Reset returns the channel to NORMAL with its relay closed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_NORMAL;
        cnt      <= '0;
`ifdef AUTORECLOSE_EN
        timer    <= '0;
        attempts <= '0;
`endif
      end else begin
        state    <= state_next;
        cnt      <= cnt_next;
`ifdef AUTORECLOSE_EN
        timer    <= timer_next;
        attempts <= attempts_next;
`endif
      end
    end

    // Next-state logic. Blanking overrides everything, and clear overrides a same-cycle trip.
    always_comb begin
      state_next    = state;
      cnt_next      = cnt;
`ifdef AUTORECLOSE_EN
      timer_next    = timer;
      attempts_next = attempts;
`endif
      if (!armed) begin
        state_next = ST_NORMAL;
        cnt_next   = '0;
      end else if (clr_i[gi]) begin
        state_next = ST_NORMAL;
        cnt_next   = '0;
`ifdef AUTORECLOSE_EN
        timer_next = '0;
        if (state != ST_NORMAL && state != ST_PEND) begin
          attempts_next = '0;
        end
`endif
      end else begin
        case (state)
          ST_NORMAL: begin
            if (over) begin
              state_next = ST_PEND;
              cnt_next   = CW'(1);
            end else begin
              cnt_next   = '0;
            end
          end
          ST_PEND: begin
            if (!over) begin
              state_next = ST_NORMAL;
              cnt_next   = '0;
            end else if (cnt == CW'(DEBOUNCE)) begin
              cnt_next   = '0;
`ifdef AUTORECLOSE_EN
              timer_next = '0;
              if (attempts == AW'(MAX_RECLOSE)) begin
                state_next = ST_LOCK;
              end else begin
                state_next = ST_TRIP;
              end
`else
              state_next = ST_TRIP;
`endif
            end else begin
              cnt_next   = cnt + CW'(1);
            end
          end
`ifdef AUTORECLOSE_EN
          // The open interval covers TRIP plus WAIT. It lasts RECLOSE_CYC cycles in total.
          ST_TRIP, ST_WAIT: begin
            if (timer == RW'(RECLOSE_CYC - 1)) begin
              state_next = ST_NORMAL;
              timer_next = '0;
              if (attempts != AW'(MAX_RECLOSE)) begin
                attempts_next = attempts + AW'(1);
              end
            end else begin
              state_next = ST_WAIT;
              timer_next = timer + RW'(1);
            end
          end
          ST_LOCK: begin
            state_next = ST_LOCK;
          end
`else
          // Latched trip. Only a clear or a reset leaves this state.
          ST_TRIP: begin
            state_next = ST_TRIP;
          end
`endif
          default: begin
            state_next = ST_NORMAL;
            cnt_next   = '0;
          end
        endcase
      end
    end

    assign relay_o[gi] = (state == ST_NORMAL) || (state == ST_PEND);
    assign trip_o[gi]  = !((state == ST_NORMAL) || (state == ST_PEND));
    assign pend_o[gi]  = (state == ST_PEND);
    assign active[gi]  = (state != ST_NORMAL);
  end

  assign armed_o  = armed;
  assign buzzer_o = !(armed && (|active));

endmodule

// File: tb/tb_overcurrent_guard_nch.sv
// Testbench for overcurrent_guard_nch.
// Inputs are directed and random. Outputs are compared each cycle against a
// run-length reference model.
module tb_overcurrent_guard_nch;
  localparam int N_CH        = 3;
  localparam int DW          = 16;
  localparam int TRIP_THR    = 500;
  localparam int NEG_LIMIT   = 32000;
  localparam int DEBOUNCE    = 4;
  localparam int STARTUP_CYC = 10;
  localparam int RECLOSE_CYC = 8;
  localparam int MAX_RECLOSE = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_CH*DW-1:0] sample;
  logic [N_CH-1:0]    clr;
  logic [N_CH-1:0]    relay;
  logic               buzzer;
  logic [N_CH-1:0]    trip;
  logic [N_CH-1:0]    pend;
  logic               armed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state. A channel counts consecutive over cycles while armed.
  // It opens on the (DEBOUNCE+1)th over cycle and stays open until cleared
  // (or, with reclose, until RECLOSE_CYC cycles have elapsed).
  int m_edges;
  int m_run  [N_CH];
  bit m_open [N_CH];
  bit m_lock [N_CH];
  int m_att  [N_CH];
  int m_timer[N_CH];

  overcurrent_guard_nch #(
    .N_CH(N_CH), .DW(DW), .TRIP_THR(TRIP_THR), .NEG_LIMIT(NEG_LIMIT),
    .DEBOUNCE(DEBOUNCE), .STARTUP_CYC(STARTUP_CYC),
    .RECLOSE_CYC(RECLOSE_CYC), .MAX_RECLOSE(MAX_RECLOSE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample), .clr_i(clr),
    .relay_o(relay), .buzzer_o(buzzer), .trip_o(trip), .pend_o(pend), .armed_o(armed)
  );

  always #5 clk = ~clk;

  function automatic logic [N_CH*DW-1:0] pk(input int a, input int b, input int c);
    return {DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic void model_reset();
    m_edges = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_run[k] = 0; m_open[k] = 1'b0; m_lock[k] = 1'b0; m_att[k] = 0; m_timer[k] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [N_CH*DW-1:0] s, input logic [N_CH-1:0] c);
    bit arm_now;
    arm_now = (m_edges >= STARTUP_CYC);
    for (int k = 0; k < N_CH; k++) begin
      int v;
      bit ov;
      v  = int'(s[k*DW +: DW]);
      ov = (v > TRIP_THR) && (v < NEG_LIMIT);
      if (!arm_now) begin
        m_run[k] = 0;
      end else if (c[k]) begin
        m_run[k] = 0;
        if (m_open[k]) begin
          m_open[k] = 1'b0; m_lock[k] = 1'b0; m_att[k] = 0; m_timer[k] = 0;
        end
      end else if (m_open[k]) begin
`ifdef AUTORECLOSE_EN
        if (!m_lock[k]) begin
          m_timer[k]++;
          if (m_timer[k] == RECLOSE_CYC) begin
            m_open[k] = 1'b0; m_timer[k] = 0; m_att[k]++;
          end
        end
`endif
      end else if (ov) begin
        m_run[k]++;
        if (m_run[k] > DEBOUNCE) begin
          m_run[k] = 0; m_open[k] = 1'b1; m_timer[k] = 0;
`ifdef AUTORECLOSE_EN
          m_lock[k] = (m_att[k] == MAX_RECLOSE);
`endif
        end
      end else begin
        m_run[k] = 0;
      end
    end
    if (m_edges < STARTUP_CYC) m_edges++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all(input string pfx);
    logic [N_CH-1:0] e_relay, e_trip, e_pend;
    bit e_armed, any_act;
    e_armed = (m_edges >= STARTUP_CYC);
    any_act = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      e_relay[k] = !m_open[k];
      e_trip[k]  = m_open[k];
      e_pend[k]  = (m_run[k] > 0);
      if (m_open[k] || m_run[k] > 0) any_act = 1'b1;
    end
    chk({pfx, ".relay"},  32'(relay),  32'(e_relay));
    chk({pfx, ".trip"},   32'(trip),   32'(e_trip));
    chk({pfx, ".pend"},   32'(pend),   32'(e_pend));
    chk({pfx, ".armed"},  32'(armed),  32'(e_armed));
    chk({pfx, ".buzzer"}, 32'(buzzer), 32'(!(e_armed && any_act)));
  endtask

  task automatic step(input string pfx, input logic [N_CH*DW-1:0] s, input logic [N_CH-1:0] c);
    sample = s;
    clr    = c;
    @(posedge clk);
    model_edge(s, c);
    cyc++;
    #1;
    $display("cyc=%0d %s s=%h clr=%b relay=%b trip=%b pend=%b buz=%b armed=%b",
             cyc, pfx, s, c, relay, trip, pend, buzzer, armed);
    compare_all(pfx);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N_CH*DW-1:0] s;
    logic [N_CH-1:0]    c;
    int                 cat[N_CH];
    int                 bv[4];
    int                 r;
    bv = '{500, 501, 31999, 32000};
    rst_n  = 1'b0;
    sample = '0;
    clr    = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;

    // Blanking with ch0 over and ch2 invalid. Ch0 trips 5 edges after arming.
    repeat (15) step("blank", pk(600, 0, 40000), '0);
    step("clr0", pk(0, 0, 40000), 3'b001);
    step("idle", pk(0, 0, 40000), '0);
    // Ch1 burst of 4, a gap, then a burst of 5 that trips.
    repeat (4) step("burst1", pk(0, 600, 40000), '0);
    step("gap", pk(0, 100, 40000), '0);
    repeat (5) step("burst2", pk(0, 600, 40000), '0);
    step("clr1", pk(0, 0, 40000), 3'b010);
    // Threshold and invalid-limit boundaries.
    repeat (8) step("at_thr", pk(500, 32000, 40000), '0);
    repeat (5) step("above_thr", pk(501, 31999, 0), '0);
    step("clr01", pk(0, 0, 0), 3'b011);
    // Clear while still over, then a full re-debounce.
    repeat (5) step("trip0", pk(600, 0, 0), '0);
    step("clr_over", pk(600, 0, 0), 3'b001);
    repeat (6) step("retrip0", pk(600, 0, 0), '0);
    // Clear beats a same-cycle trip.
    step("clr0b", pk(0, 0, 0), 3'b001);
    repeat (4) step("pend0", pk(600, 0, 0), '0);
    step("clr_wins", pk(600, 0, 0), 3'b001);
    step("idle2", pk(0, 0, 0), '0);
    // Simultaneous trips, then reset mid-trip and restart blanking.
    repeat (5) step("dual", pk(600, 600, 0), '0);
    pulse_reset();
    repeat (12) step("reblank", pk(600, 600, 600), '0);
    // Long over run on ch0. With reclose this walks trip/reclose to lockout.
    step("clr_all", pk(0, 0, 0), 3'b111);
    repeat (60) step("hold0", pk(600, 0, 0), '0);
    step("release", pk(0, 0, 0), 3'b001);
    step("idle3", pk(0, 0, 0), '0);

    // Random phase. Each channel keeps a sample category for a while, so runs long enough to trip do occur.
    for (int k = 0; k < N_CH; k++) cat[k] = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      for (int k = 0; k < N_CH; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          r = int'($urandom_range(0, 9));
          cat[k] = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
        end
        case (cat[k])
          0:       s[k*DW +: DW] = DW'($urandom_range(501, 31999));
          1:       s[k*DW +: DW] = DW'($urandom_range(0, 500));
          2:       s[k*DW +: DW] = DW'($urandom_range(32000, 65535));
          default: s[k*DW +: DW] = DW'(bv[$urandom_range(0, 3)]);
        endcase
        c[k] = ($urandom_range(0, 29) == 0);
      end
      step("rand", s, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
